simon_keysched_param: RTL and testbench
=======================================

SIMON_KEYSCHED_PARAM -- requirements
Module: simon_keysched_param

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- N, 64, word size in bits; legal values 16, 24, 32, 48, 64.
- M, 2, number of key words; legal values 2, 3, 4.
- ZSEL, 2, index of the SIMON constant sequence z0..z4; legal values 0..4.
- T, 68, total number of round keys; T SHALL be >= M+1 and <= 255.
REQ-002 An illegal N, M, ZSEL or T value SHALL be rejected at elaboration.
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state is updated on its rising edge.
- rst  input  1  asynchronous active-high reset.
- clear  input  1  synchronous abort; returns the block to the LOAD state.
- load_en  input  1  qualifies data_in as one serial key bit.
- data_in  input  1  serial key bit.
- adv  input  1  request to advance to the next round key.
- key_out  output  N  current round key.
- key_valid  output  1  key_out holds round key number round_idx.
- round_idx  output  8  index of the round key currently on key_out.
- done  output  1  all T round keys have been delivered.

Function
REQ-004 The block SHALL hold key words K[0]..K[M-1], each N bits wide, with key_out = K[0] at all times.
REQ-005 The state machine SHALL have the states LOAD, READY and DONE; the reset state SHALL be LOAD.
REQ-006 In LOAD, each cycle with load_en=1 SHALL shift the concatenation {K[M-1],...,K[0]} right by one bit, with data_in entering at bit N*M-1, and SHALL increment the bit counter.
- Consequence: the first bit loaded ends up in K[0][0].
REQ-007 The clock edge on which the (N*M)th bit is accepted SHALL move the block to READY, with round_idx=0 and key_valid=1 in the next cycle.
REQ-008 Outside LOAD, load_en SHALL be ignored.
REQ-009 In READY, with adv=1 and round_idx < T-1, the block SHALL compute a new word W:
- tmp = ROR(K[M-1],3).
- If M=4: tmp = tmp ^ K[1].
- tmp = tmp ^ ROR(tmp,1).
- W = ~K[0] ^ tmp ^ z_ZSEL[j] ^ 3, where j = (round_idx) mod 62.
REQ-010 On the same edge, the block SHALL shift K[i] <= K[i+1] for i < M-1, set K[M-1] <= W, and increment round_idx.
- Latency: exactly one cycle per advance; key_valid SHALL remain 1.
REQ-011 z_ZSEL SHALL be the standard 62-element SIMON sequence; element 0 is the first element of that sequence.
REQ-012 In READY, with adv=1 and round_idx = T-1, the block SHALL move to DONE: key_valid=0, done=1, and round_idx and K held.
REQ-013 adv SHALL be ignored in LOAD and in DONE.
REQ-014 In DONE, the block SHALL stay put until clear or rst.
REQ-015 clear=1 in any state SHALL, on the next edge:
- move the block to LOAD;
- zero the bit counter, round_idx, key_valid and done;
- leave K unchanged.
REQ-016 clear SHALL take priority over load_en and adv in the same cycle.
REQ-017 The modulo-62 index SHALL wrap correctly for T > 62; for example, round_idx 62 uses z[0].
REQ-018 All arithmetic SHALL be N-bit, and rotations SHALL be within N bits.

Reset
REQ-019 While rst=1, the block SHALL asynchronously force:
- state = LOAD;
- K[*] = 0, bit counter = 0, round_idx = 0;
- key_valid = 0, done = 0, key_out = 0.
REQ-020 A reset asserted mid-load or mid-run SHALL discard all progress; after release, a full N*M-bit load is required.

Verification
REQ-021 Scenario: N=64, M=2, ZSEL=2, T=68; serially load key 0f0e0d0c0b0a0908_0706050403020100, LSB first.
- key_valid rises one cycle after bit 128.
- key_out = 0706050403020100 at round 0.
- After one adv, key_out = 0f0e0d0c0b0a0908 at round 1.
REQ-022 Scenario: same configuration; assert adv continuously for 67 cycles.
- Every key_out SHALL match the golden software SIMON128/128 schedule.
- At round_idx 67, the next adv SHALL give done=1 and key_valid=0.
REQ-023 Scenario: N=16, M=4, ZSEL=0, T=32; load key 1918_1110_0908_0100.
- Rounds 0-3 SHALL give 0100, 0908, 1110, 1918.
- Rounds 4-31 SHALL match the golden SIMON32/64 model, which exercises the M=4 path.
REQ-024 Scenario: N=32, M=3, ZSEL=0, T=80 (wraps past j=61); compare all 80 keys against the golden model.
REQ-025 Scenario: boundary events.
- clear and adv in the same cycle in READY -> LOAD with round_idx 0.
- rst pulse during bit 50 of a load -> key_out 0 immediately, and a reload succeeds.
- adv in LOAD -> no effect.

Source files
------------

// File: rtl/simon_keysched_param.sv
// SIMON key schedule: a serially loaded M-word key of N-bit words is expanded into T round keys.
// One round key is presented on key_out per adv request.
module simon_keysched_param #(
    parameter int N    = 64,
    parameter int M    = 2,
    parameter int ZSEL = 2,
    parameter int T    = 68
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load_en,
    input  logic         data_in,
    input  logic         adv,
    output logic [N-1:0] key_out,
    output logic         key_valid,
    output logic [7:0]   round_idx,
    output logic         done
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        READY = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [M-1:0][N-1:0] key_t;

    localparam int KW = N * M;
    localparam int CW = $clog2(KW);

    // Element 0 of each sequence is the leftmost (most significant) bit here.
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    localparam logic [61:0] Z_SEQ = (ZSEL == 0) ? Z0 :
                                    (ZSEL == 1) ? Z1 :
                                    (ZSEL == 2) ? Z2 :
                                    (ZSEL == 3) ? Z3 : Z4;

    localparam logic [CW-1:0] LAST_BIT   = CW'(KW - 1);
    localparam logic [7:0]    LAST_ROUND = 8'(T - 1);

    generate
        if (!(N == 16 || N == 24 || N == 32 || N == 48 || N == 64)) begin : g_bad_n
            $error("simon_keysched_param: illegal N");
        end
        if (!(M == 2 || M == 3 || M == 4)) begin : g_bad_m
            $error("simon_keysched_param: illegal M");
        end
        if (ZSEL < 0 || ZSEL > 4) begin : g_bad_zsel
            $error("simon_keysched_param: illegal ZSEL");
        end
        if (T < M + 1 || T > 255) begin : g_bad_t
            $error("simon_keysched_param: illegal T");
        end
    endgenerate

    function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int unsigned r);
        return (x >> r) | (x << (N - r));
    endfunction

    // Next key word from the current window; idx is the round of the key in k[0].
    function automatic logic [N-1:0] new_word(input key_t k, input logic [7:0] idx);
        logic [N-1:0] tmp;
        logic [5:0]   j;
        j   = 6'(idx % 8'd62);
        tmp = ror(k[M-1], 3);
        if (M == 4) begin
            tmp = tmp ^ k[1];
        end
        tmp = tmp ^ ror(tmp, 1);
        return ~k[0] ^ tmp ^ {{(N-1){1'b0}}, Z_SEQ[6'd61 - j]} ^ {{(N-2){1'b0}}, 2'b11};
    endfunction

    state_t          state_r, state_s;
    key_t            key_r, key_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [7:0]      round_r, round_s;
    logic            valid_r, valid_s;
    logic            done_r, done_s;
    logic [KW-1:0]   flat_s;

    // Next-state and datapath update; clear overrides everything else.
    always_comb begin
        state_s = state_r;
        key_s   = key_r;
        cnt_s   = cnt_r;
        round_s = round_r;
        valid_s = valid_r;
        done_s  = done_r;
        flat_s  = key_r;
        if (clear) begin
            state_s = LOAD;
            cnt_s   = {CW{1'b0}};
            round_s = 8'd0;
            valid_s = 1'b0;
            done_s  = 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (load_en) begin
                        key_s = {data_in, flat_s[KW-1:1]};
                        if (cnt_r == LAST_BIT) begin
                            state_s = READY;
                            cnt_s   = {CW{1'b0}};
                            round_s = 8'd0;
                            valid_s = 1'b1;
                        end else begin
                            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        key_s = key_r;
                    end
                end
                READY: begin
                    if (adv) begin
                        if (round_r == LAST_ROUND) begin
                            state_s = DONE;
                            valid_s = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            for (int i = 0; i < M - 1; i++) begin
                                key_s[i] = key_r[i+1];
                            end
                            key_s[M-1] = new_word(key_r, round_r);
                            round_s    = round_r + 8'd1;
                        end
                    end else begin
                        key_s = key_r;
                    end
                end
                DONE: begin
                    state_s = DONE;
                end
                default: begin
                    state_s = LOAD;
                    cnt_s   = {CW{1'b0}};
                    round_s = 8'd0;
                    valid_s = 1'b0;
                    done_s  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LOAD;
            key_r   <= '0;
            cnt_r   <= {CW{1'b0}};
            round_r <= 8'd0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            key_r   <= key_s;
            cnt_r   <= cnt_s;
            round_r <= round_s;
            valid_r <= valid_s;
            done_r  <= done_s;
        end
    end

    assign key_out   = key_r[0];
    assign key_valid = valid_r;
    assign round_idx = round_r;
    assign done      = done_r;

endmodule

// File: tb/tb_simon_keysched_param.sv
// Bench for simon_keysched_param: three configurations checked against a
// plain-arithmetic SIMON key-expansion model, plus clear/reset/ignore corner cases.
module tb_simon_keysched_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  clr, ld, din, adv;
    logic [63:0] ko_a;
    logic [15:0] ko_b;
    logic [31:0] ko_c;
    logic [2:0]  kv, dn;
    logic [7:0]  ri [3];

    simon_keysched_param #(.N(64), .M(2), .ZSEL(2), .T(68)) u_a (
        .clk(clk), .rst(rst), .clear(clr[0]), .load_en(ld[0]), .data_in(din[0]), .adv(adv[0]),
        .key_out(ko_a), .key_valid(kv[0]), .round_idx(ri[0]), .done(dn[0]));
    simon_keysched_param #(.N(16), .M(4), .ZSEL(0), .T(32)) u_b (
        .clk(clk), .rst(rst), .clear(clr[1]), .load_en(ld[1]), .data_in(din[1]), .adv(adv[1]),
        .key_out(ko_b), .key_valid(kv[1]), .round_idx(ri[1]), .done(dn[1]));
    simon_keysched_param #(.N(32), .M(3), .ZSEL(0), .T(80)) u_c (
        .clk(clk), .rst(rst), .clear(clr[2]), .load_en(ld[2]), .data_in(din[2]), .adv(adv[2]),
        .key_out(ko_c), .key_valid(kv[2]), .round_idx(ri[2]), .done(dn[2]));

    typedef struct {
        int           sel;
        int           n;
        int           m;
        int           zsel;
        int           t;
        logic [255:0] key;
        int           spot_round;
        logic [63:0]  spot_key;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    string       zs [5];
    logic [63:0] rk [256];
    vec_t        vecs [6];

    function automatic logic [63:0] get_ko(input int s);
        case (s)
            0:       return ko_a;
            1:       return {48'd0, ko_b};
            default: return {32'd0, ko_c};
        endcase
    endfunction

    function automatic logic [63:0] mrot(input logic [63:0] x, input int r, input int n,
                                         input logic [63:0] mask);
        return ((x >> r) | (x << (n - r))) & mask;
    endfunction

    // Round keys k[0..t-1]: k[i] = c ^ z[(i-m) mod 62] ^ k[i-m] ^ f(k[i-1], k[i-3]).
    task automatic build_model(input int n, input int m, input int zsel, input int t,
                               input logic [255:0] key);
        logic [63:0] mask, tmp, zb;
        mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        for (int i = 0; i < m; i++) rk[i] = 64'(key >> (i * n)) & mask;
        for (int i = m; i < t; i++) begin
            tmp = mrot(rk[i-1], 3, n, mask);
            if (m == 4) tmp = tmp ^ rk[i-3];
            tmp = tmp ^ mrot(tmp, 1, n, mask);
            zb  = (zs[zsel][(i - m) % 62] == "1") ? 64'd1 : 64'd0;
            rk[i] = (mask - 64'd3) ^ zb ^ rk[i-m] ^ tmp;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int s, input logic [63:0] k,
                               input int r, input logic v, input logic d);
        chk({tag, "_key"},   get_ko(s),  k);
        chk({tag, "_round"}, 64'(ri[s]), 64'(r));
        chk({tag, "_valid"}, 64'(kv[s]), 64'(v));
        chk({tag, "_done"},  64'(dn[s]), 64'(d));
    endtask

    task automatic load_bits(input int s, input logic [255:0] key, input int nb);
        for (int b = 0; b < nb; b++) begin
            ld[s]  = 1'b1;
            din[s] = key[b];
            tick();
        end
        ld[s]  = 1'b0;
        din[s] = 1'b0;
    endtask

    task automatic full_load(input int s, input logic [255:0] key, input int nb, input string tag);
        load_bits(s, key, nb - 1);
        chk({tag, "_early_valid"}, 64'(kv[s]), 64'd0);
        load_bits(s, key >> (nb - 1), 1);
        check_state(tag, s, rk[0], 0, 1'b1, 1'b0);
    endtask

    task automatic run_sched(input vec_t v);
        int s, round, budget;
        logic a;
        s = v.sel;
        build_model(v.n, v.m, v.zsel, v.t, v.key);
        full_load(s, v.key, v.n * v.m, "loaded");
        if (v.spot_round == 0) chk("spot", get_ko(s), v.spot_key);
        round  = 0;
        budget = 0;
        while (round < v.t - 1 && budget < 1000) begin
            a      = ($urandom_range(0, 3) != 0);
            adv[s] = a;
            tick();
            if (a) round++;
            chk("step_key",   get_ko(s),  rk[round]);
            chk("step_round", 64'(ri[s]), 64'(round));
            chk("step_valid", 64'(kv[s]), 64'd1);
            if (a && round == v.spot_round) chk("spot", get_ko(s), v.spot_key);
            budget++;
        end
        adv[s] = 1'b0;
        chk("adv_budget", 64'(round), 64'(v.t - 1));
        adv[s] = 1'b1;
        tick();
        check_state("done", s, rk[v.t-1], v.t - 1, 1'b0, 1'b1);
        tick();
        check_state("done_hold", s, rk[v.t-1], v.t - 1, 1'b0, 1'b1);
        adv[s] = 1'b0;
        clr[s] = 1'b1;
        tick();
        clr[s] = 1'b0;
        check_state("clear", s, rk[v.t-1], 0, 1'b0, 1'b0);
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        logic [255:0] kb;
        zs[0] = "11111010001001010110000111001101111101000100101011000011100110";
        zs[1] = "10001110111110010011000010110101000111011111001001100001011010";
        zs[2] = "10101111011100000011010010011000101000010001111110010110110011";
        zs[3] = "11011011101011000110010111100000010010001010011100110100001111";
        zs[4] = "11010001111001101011011000100000010111000011001010010011101111";

        vecs[0] = '{0, 64, 2, 2, 68, 256'h0f0e0d0c0b0a0908_0706050403020100, 1, 64'h0f0e0d0c0b0a0908};
        vecs[1] = '{1, 16, 4, 0, 32, 256'h1918_1110_0908_0100, 3, 64'h1918};
        vecs[2] = '{2, 32, 3, 0, 80, 256'h13121110_0b0a0908_03020100, 2, 64'h13121110};
        kb = rand_key();
        vecs[3] = '{0, 64, 2, 2, 68, kb, 0, kb[63:0]};
        kb = rand_key();
        vecs[4] = '{1, 16, 4, 0, 32, kb, 0, {48'd0, kb[15:0]}};
        kb = rand_key();
        vecs[5] = '{2, 32, 3, 0, 80, kb, 0, {32'd0, kb[31:0]}};

        rst = 1'b1;
        clr = 3'b000;
        ld  = 3'b000;
        din = 3'b000;
        adv = 3'b000;
        tick();
        tick();
        for (int s = 0; s < 3; s++) check_state("reset", s, 64'd0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_sched(vecs[i]);

        // Corner cases on the 128/128 instance.
        kb = rand_key();
        build_model(64, 2, 2, 68, kb);
        full_load(0, kb, 128, "c_load");
        adv[0] = 1'b1;
        tick();
        tick();
        adv[0] = 1'b0;
        check_state("c_adv2", 0, rk[2], 2, 1'b1, 1'b0);
        clr[0] = 1'b1;
        adv[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        adv[0] = 1'b0;
        check_state("clr_adv", 0, rk[2], 0, 1'b0, 1'b0);
        adv[0] = 1'b1;
        tick();
        tick();
        tick();
        adv[0] = 1'b0;
        check_state("adv_in_load", 0, rk[2], 0, 1'b0, 1'b0);
        full_load(0, kb, 128, "reload");
        ld[0]  = 1'b1;
        din[0] = 1'b1;
        tick();
        tick();
        tick();
        ld[0]  = 1'b0;
        din[0] = 1'b0;
        check_state("ld_in_ready", 0, rk[0], 0, 1'b1, 1'b0);

        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        kb = rand_key();
        kb[0] = 1'b1;
        build_model(64, 2, 2, 68, kb);
        load_bits(0, kb, 50);
        ld[0]  = 1'b1;
        din[0] = kb[50];
        #2;
        rst = 1'b1;
        #1;
        check_state("rst_mid", 0, 64'd0, 0, 1'b0, 1'b0);
        ld[0]  = 1'b0;
        din[0] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        full_load(0, kb, 128, "post_rst");
        adv[0] = 1'b1;
        tick();
        adv[0] = 1'b0;
        check_state("post_rst_adv", 0, rk[1], 1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
